// File: rtl/multi_dataflow_engine_monitor.sv
// multi_dataflow_engine_monitor
// Engine-side controller/monitor between the HWPE ctrl FSM and the kernel adapter.
// It issues the kernel start pulse, reports ready/busy/done, and counts accepted
// beats on N_OUT output streams against lengths latched at job start. It also
// flags overruns (sticky) and stall timeouts (sticky ERR state).
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   start_i, len_i[N_OUT*CNT_W], timeout_i[TO_W]   job request and parameters
//   k_ready_i, k_idle_i, k_done_i                 kernel adapter status
//   out_valid_i[N_OUT], out_ready_i[N_OUT]        output stream handshakes
//   k_start_o, ready_o, busy_o, done_o            control/status flags
//   cnt_o[N_OUT*CNT_W]                            per-stream accepted-beat counters
//   overrun_o, err_o                              sticky error flags
module multi_dataflow_engine_monitor #(
    parameter int unsigned N_OUT = 2,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TO_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [N_OUT*CNT_W-1:0] len_i,
    input  logic [TO_W-1:0]        timeout_i,
    input  logic                   k_ready_i,
    input  logic                   k_idle_i,
    input  logic                   k_done_i,
    input  logic [N_OUT-1:0]       out_valid_i,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic                   k_start_o,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_OUT*CNT_W-1:0] cnt_o,
    output logic                   overrun_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_ready;
    logic                   r_kstart;
    logic                   r_kdone;
    logic                   r_overrun;
    logic [N_OUT*CNT_W-1:0] r_cnt;
    logic [N_OUT*CNT_W-1:0] r_len;
    logic [N_OUT*CNT_W-1:0] w_cnt_next;
    logic [TO_W-1:0]        r_timeout;
    logic [TO_W-1:0]        r_stall;
    logic [N_OUT-1:0]       w_hs;
    logic                   w_any_hs;
    logic                   w_start;
    logic                   w_all_cnt;
    logic                   w_overrun_hit;
    logic                   w_timeout_hit;

    assign w_hs     = out_valid_i & out_ready_i;
    assign w_any_hs = |w_hs;
    // A start request is only honoured while the registered ready flag is up.
    assign w_start  = (r_state == StIdle) && start_i && r_ready;
    assign w_timeout_hit = (r_timeout != '0) && (r_stall == r_timeout);

    // Per-stream counting: increment below length, otherwise hold and flag overrun.
    always_comb begin
        w_cnt_next    = r_cnt;
        w_overrun_hit = 1'b0;
        w_all_cnt     = 1'b1;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (r_cnt[k*CNT_W +: CNT_W] != r_len[k*CNT_W +: CNT_W]) begin
                w_all_cnt = 1'b0;
            end
            if (w_hs[k]) begin
                if (r_cnt[k*CNT_W +: CNT_W] < r_len[k*CNT_W +: CNT_W]) begin
                    w_cnt_next[k*CNT_W +: CNT_W] = r_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                end else begin
                    w_overrun_hit = 1'b1;
                end
            end
        end
    end

    // Completion is judged on registered state, so it wins over a same-edge timeout.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) w_state_next = StRun;
            end
            StRun: begin
                if (w_all_cnt && r_kdone) begin
                    w_state_next = StDone;
                end else if (w_timeout_hit) begin
                    w_state_next = StErr;
                end
            end
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StErr;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_ready   <= 1'b0;
            r_kstart  <= 1'b0;
            r_kdone   <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_timeout <= '0;
            r_stall   <= '0;
        end else if (clear_i) begin
            r_state   <= StIdle;
            r_ready   <= 1'b0;
            r_kstart  <= 1'b0;
            r_kdone   <= 1'b0;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_timeout <= '0;
            r_stall   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ready  <= (r_state == StIdle) && (k_ready_i || k_idle_i);
            r_kstart <= w_start;
            if (w_start) begin
                r_len     <= len_i;
                r_timeout <= timeout_i;
                r_cnt     <= '0;
                r_kdone   <= 1'b0;
                r_stall   <= '0;
            end else if (r_state == StRun) begin
                r_cnt <= w_cnt_next;
                if (w_overrun_hit) r_overrun <= 1'b1;
                if (k_done_i) r_kdone <= 1'b1;
                if (w_any_hs) begin
                    r_stall <= '0;
                end else if (r_stall != '1) begin
                    r_stall <= r_stall + TO_W'(1);
                end
            end
        end
    end

    assign k_start_o = r_kstart;
    assign ready_o   = r_ready;
    assign busy_o    = (r_state == StRun);
    assign done_o    = (r_state == StDone);
    assign err_o     = (r_state == StErr);
    assign cnt_o     = r_cnt;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_multi_dataflow_engine_monitor.sv
module tb_multi_dataflow_engine_monitor;

    localparam int unsigned N_OUT = 2;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO_W  = 16;

    logic                   clk_i;
    logic                   rst_i;
    logic                   clear_i;
    logic                   start_i;
    logic [N_OUT*CNT_W-1:0] len_i;
    logic [TO_W-1:0]        timeout_i;
    logic                   k_ready_i;
    logic                   k_idle_i;
    logic                   k_done_i;
    logic [N_OUT-1:0]       out_valid_i;
    logic [N_OUT-1:0]       out_ready_i;
    logic                   k_start_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   done_o;
    logic [N_OUT*CNT_W-1:0] cnt_o;
    logic                   overrun_o;
    logic                   err_o;

    int checks = 0;
    int errors = 0;

    multi_dataflow_engine_monitor #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W),
        .TO_W  (TO_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .timeout_i   (timeout_i),
        .k_ready_i   (k_ready_i),
        .k_idle_i    (k_idle_i),
        .k_done_i    (k_done_i),
        .out_valid_i (out_valid_i),
        .out_ready_i (out_ready_i),
        .k_start_o   (k_start_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cnt_o       (cnt_o),
        .overrun_o   (overrun_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        timeout_i   = '0;
        k_ready_i   = 1'b0;
        k_idle_i    = 1'b0;
        k_done_i    = 1'b0;
        out_valid_i = '0;
        out_ready_i = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_i    = 1'b0;
        k_idle_i = 1'b1;
        chk("ready_pre", 64'(ready_o), 64'd0);
        tick();
        chk("ready_lat1", 64'(ready_o), 64'd1);

        // Job 1: stream1 len 4, stream0 len 3, k_done with last beat
        start_i = 1'b1;
        len_i   = {16'd4, 16'd3};
        tick();
        start_i = 1'b0;
        chk("j1_kstart", 64'(k_start_o), 64'd1);
        chk("j1_busy", 64'(busy_o), 64'd1);
        out_valid_i = 2'b11;
        out_ready_i = 2'b11;
        tick();
        chk("j1_kstart_off", 64'(k_start_o), 64'd0);
        tick();
        chk("j1_ready_run", 64'(ready_o), 64'd0);
        tick();
        chk("j1_cnt_mid", 64'(cnt_o), 64'h0003_0003);
        out_valid_i = 2'b10;
        k_done_i    = 1'b1;
        tick();
        out_valid_i = 2'b00;
        k_done_i    = 1'b0;
        chk("j1_cnt_final", 64'(cnt_o), 64'h0004_0003);
        chk("j1_done_e0", 64'(done_o), 64'd0);
        tick();
        chk("j1_done_e1", 64'(done_o), 64'd1);
        chk("j1_busy_done", 64'(busy_o), 64'd0);
        tick();
        chk("j1_done_e2", 64'(done_o), 64'd0);
        chk("j1_cnt_hold", 64'(cnt_o), 64'h0004_0003);
        chk("j1_overrun", 64'(overrun_o), 64'd0);
        tick();

        // Job 2: stream0 len 0, stream1 len 2, k_done late
        chk("j2_ready", 64'(ready_o), 64'd1);
        start_i = 1'b1;
        len_i   = {16'd2, 16'd0};
        tick();
        start_i = 1'b0;
        chk("j2_cnt_zeroed", 64'(cnt_o), 64'd0);
        out_valid_i = 2'b10;
        tick();
        tick();
        out_valid_i = 2'b00;
        chk("j2_cnt", 64'(cnt_o), 64'h0002_0000);
        repeat (5) tick();
        chk("j2_wait_done", 64'(done_o), 64'd0);
        chk("j2_wait_busy", 64'(busy_o), 64'd1);
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("j2_done_e0", 64'(done_o), 64'd0);
        tick();
        chk("j2_done_e1", 64'(done_o), 64'd1);
        tick();
        tick();

        // Job 3: len {2,2}, three beats on stream0 -> overrun, still completes
        start_i = 1'b1;
        len_i   = {16'd2, 16'd2};
        tick();
        start_i = 1'b0;
        out_valid_i = 2'b11;
        tick();
        tick();
        out_valid_i = 2'b01;
        k_done_i    = 1'b1;
        tick();
        out_valid_i = 2'b00;
        k_done_i    = 1'b0;
        chk("j3_cnt_sat", 64'(cnt_o), 64'h0002_0002);
        chk("j3_overrun", 64'(overrun_o), 64'd1);
        tick();
        chk("j3_done", 64'(done_o), 64'd1);
        tick();
        tick();

        // Job 4: timeout 8 with no beats -> ERR
        start_i   = 1'b1;
        len_i     = {16'd1, 16'd1};
        timeout_i = 16'd8;
        tick();
        start_i   = 1'b0;
        timeout_i = 16'd0;
        repeat (8) tick();
        chk("j4_err_early", 64'(err_o), 64'd0);
        chk("j4_busy_early", 64'(busy_o), 64'd1);
        tick();
        chk("j4_err", 64'(err_o), 64'd1);
        chk("j4_busy_err", 64'(busy_o), 64'd0);
        tick();
        chk("j4_ready_err", 64'(ready_o), 64'd0);
        chk("j4_overrun_sticky", 64'(overrun_o), 64'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("j4_start_ignored", 64'(k_start_o), 64'd0);
        chk("j4_err_hold", 64'(err_o), 64'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("j4_clr_err", 64'(err_o), 64'd0);
        chk("j4_clr_overrun", 64'(overrun_o), 64'd0);
        chk("j4_clr_busy", 64'(busy_o), 64'd0);
        tick();

        // Job 5: clear and start in the same cycle mid-RUN
        chk("j5_ready", 64'(ready_o), 64'd1);
        start_i = 1'b1;
        len_i   = {16'd3, 16'd3};
        tick();
        start_i     = 1'b0;
        out_valid_i = 2'b11;
        tick();
        out_valid_i = 2'b00;
        chk("j5_cnt_one", 64'(cnt_o), 64'h0001_0001);
        clear_i = 1'b1;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("j5_clr_busy", 64'(busy_o), 64'd0);
        chk("j5_clr_cnt", 64'(cnt_o), 64'd0);
        chk("j5_clr_kstart", 64'(k_start_o), 64'd0);
        chk("j5_clr_ready", 64'(ready_o), 64'd0);
        tick();
        chk("j5_ready_back", 64'(ready_o), 64'd1);

        // Job 6: asynchronous reset mid-RUN
        start_i = 1'b1;
        tick();
        start_i     = 1'b0;
        out_valid_i = 2'b11;
        tick();
        out_valid_i = 2'b00;
        chk("j6_busy_pre", 64'(busy_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("j6_rst_busy", 64'(busy_o), 64'd0);
        chk("j6_rst_cnt", 64'(cnt_o), 64'd0);
        chk("j6_rst_ready", 64'(ready_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("j6_no_done", 64'(done_o), 64'd0);
        chk("j6_ready_after", 64'(ready_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
